apb_master_bridge: RTL and testbench

//  Upstream APB requester for the student-info register slave: converts single-beat commands
//  (valid/ready) into APB3 SETUP/ACCESS transfers and returns read data/status as a response pulse.

---
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-beat command to APB3 requester: one transfer in flight, one-cycle response pulse.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // state     | meaning
    // ST_IDLE   | ready for a command; misaligned commands are answered from here
    // ST_SETUP  | APB setup phase (PSEL=1, PENABLE=0), always one cycle
    // ST_ACCESS | APB access phase, waiting for PREADY (or timeout)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic misalign;
    logic xfer_done;
    logic tmo_hit;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Down-counter of remaining stalled ACCESS cycles, armed when a transfer is launched.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt <= '0;
        end else if (accept && !misalign) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        end else if (state == ST_ACCESS && !PREADY && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // PREADY on the terminal edge takes priority, so the stall qualifier is part of the hit.
    assign tmo_hit = (state == ST_ACCESS) && !PREADY && (tmo_cnt == TMO_W'(1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        misalign  = 1'b0;
        xfer_done = 1'b0;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    misalign = (cmd_addr[1:0] != 2'b00);
                    if (cmd_addr[1:0] == 2'b00) begin
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    xfer_done = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // APB address/data hold their last value between transfers; responses are single-cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            if (accept && misalign) begin
                rsp_valid <= 1'b1;
                rsp_error <= 1'b1;
            end
            if (accept && !misalign) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_write ? cmd_wdata : '0;
            end
            if (xfer_done) begin
                rsp_valid <= 1'b1;
                if (!PWRITE) begin
                    rsp_rdata <= PRDATA;
                end
            end else if (tmo_hit) begin
                rsp_valid <= 1'b1;
                rsp_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: APB slave memory model plus a command-level scoreboard.
// Build with or without APB_MASTER_TIMEOUT_EN; the stall tests adapt to the selected behaviour.
module tb_apb_master_bridge;

    localparam int TMO = 16;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_master_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard: what each word should hold, from the commands issued.
    logic [31:0] model_mem [int];
    // Slave storage: what the bridge actually wrote over APB.
    logic [31:0] slv_mem [int];
    int          force_waits = -1;
    int          slv_wait    = 0;
    int          last_waits  = 0;
    logic        slv_hang    = 1'b0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(int'(a >> 2)) ? model_mem[int'(a >> 2)] : 32'h0;
    endfunction

    // Slave: picks a wait count in SETUP, then answers in ACCESS.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            PREADY = 1'b0;
        end else if (PSEL && !PENABLE) begin
            slv_wait   = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
            last_waits = slv_wait;
            PREADY     = 1'b0;
            PRDATA     = $urandom;
        end else if (PSEL && PENABLE && !slv_hang) begin
            if (slv_wait == 0) begin
                PREADY = 1'b1;
                if (PWRITE) begin
                    slv_mem[int'(PADDR >> 2)] = PWDATA;
                    PRDATA = $urandom;
                end else begin
                    PRDATA = slv_mem.exists(int'(PADDR >> 2)) ? slv_mem[int'(PADDR >> 2)] : 32'h0;
                end
            end else begin
                slv_wait--;
                PREADY = 1'b0;
                PRDATA = $urandom;
            end
        end else begin
            PREADY = 1'b0;
            PRDATA = $urandom;
        end
    end

    // Called at the SETUP-cycle negedge; returns at the response-cycle negedge.
    task automatic wait_rsp(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_tmo);
        int lat;
        int exp_lat;
        lat = 1;
        while (lat < 60) begin
            @(negedge PCLK);
            lat++;
            if (rsp_valid) break;
            chk("access_phase", {30'h0, PSEL, PENABLE}, 32'h3);
            chk("access_paddr", PADDR, addr);
        end
        chk("rsp_seen", rsp_valid, 1'b1);
        exp_lat = exp_tmo ? (2 + TMO) : (3 + last_waits);
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_error", rsp_error, exp_tmo);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_bus_idle", {30'h0, PSEL, PENABLE}, 32'h0);
        chk("rsp_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic exp_tmo);
        logic        mis;
        logic [31:0] exp_rd;
        mis    = (addr[1:0] != 2'b00);
        exp_rd = (wr || mis || exp_tmo) ? 32'h0 : model_rd(addr);
        if (wr && !mis && !exp_tmo) model_mem[int'(addr >> 2)] = wd;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = $urandom_range(0, 1);
        if (mis) begin
            chk("mis_rsp_valid", rsp_valid, 1'b1);
            chk("mis_rsp_error", rsp_error, 1'b1);
            chk("mis_rsp_rdata", rsp_rdata, 32'h0);
            chk("mis_no_psel", PSEL, 1'b0);
        end else begin
            chk("setup_phase", {30'h0, PSEL, PENABLE}, 32'h2);
            chk("setup_paddr", PADDR, addr);
            chk("setup_pwrite", PWRITE, wr);
            chk("setup_pwdata", PWDATA, wr ? wd : 32'h0);
            wait_rsp(addr, exp_rd, exp_tmo);
        end
        @(negedge PCLK);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_rsp_rdata", rsp_rdata, 32'h0);
        chk("post_rsp_error", rsp_error, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd2;
        int          bad;
        int          n;

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        PREADY    = 1'b0;
        PRDATA    = 32'h0;

        repeat (2) @(negedge PCLK);
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_error", rsp_error, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // Directed write then read-back with one wait state.
        force_waits = 1;
        run_cmd(1'b1, 32'h4, 32'h15032024, 1'b0);
        run_cmd(1'b0, 32'h4, 32'h0, 1'b0);
        force_waits = 0;
        run_cmd(1'b0, 32'h4, 32'h0, 1'b0);

        // Back-to-back: command held valid, second accepted in the response cycle.
        force_waits = -1;
        d = $urandom;
        model_mem[2] = d;
        exp_rd2   = model_rd(32'hC);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h8;
        cmd_wdata = d;
        chk("b2b_ready", cmd_ready, 1'b1);
        @(negedge PCLK);
        cmd_write = 1'b0;
        cmd_addr  = 32'hC;
        cmd_wdata = $urandom;
        chk("b2b_setup_paddr", PADDR, 32'h8);
        chk("b2b_setup_pwrite", PWRITE, 1'b1);
        chk("b2b_blocked", cmd_ready, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("b2b_rsp1", rsp_valid, 1'b1);
        chk("b2b_gap_psel", PSEL, 1'b0);
        chk("b2b_gap_ready", cmd_ready, 1'b1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("b2b_second_setup", {30'h0, PSEL, PENABLE}, 32'h2);
        chk("b2b_second_paddr", PADDR, 32'hC);
        chk("b2b_second_pwrite", PWRITE, 1'b0);
        chk("b2b_second_rsp_low", rsp_valid, 1'b0);
        wait_rsp(32'hC, exp_rd2, 1'b0);
        @(negedge PCLK);
        chk("b2b_post_rsp", rsp_valid, 1'b0);
        run_cmd(1'b0, 32'h8, 32'h0, 1'b0);

        // Misaligned accesses.
        run_cmd(1'b0, 32'h6, 32'h0, 1'b0);
        run_cmd(1'b1, 32'h13, 32'hDEADBEEF, 1'b0);
        run_cmd(1'b0, 32'h13, 32'h0, 1'b0);

        // Randomized mix of reads, writes, misaligned addresses and idle gaps.
        for (int i = 0; i < 40; i++) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_cmd(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end

        // Stalled slave.
        slv_hang = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        run_cmd(1'b0, 32'h10, 32'h0, 1'b1);
        n = 5;
`else
        n = 120;
`endif
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h24;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            if (!(PSEL && PENABLE) || rsp_valid) bad++;
        end
        chk("stall_hold", bad, 0);

        // Reset in the middle of ACCESS.
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst_psel", PSEL, 1'b0);
        chk("arst_penable", PENABLE, 1'b0);
        chk("arst_paddr", PADDR, 32'h0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        slv_hang = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (rsp_valid) bad++;
        end
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) bad++;
        end
        chk("arst_no_rsp", bad, 0);
        chk("arst_cmd_ready", cmd_ready, 1'b1);
        run_cmd(1'b0, 32'h0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
